mem_responder: RTL

- Memory-side responder for the multicycle CPU's data-memory port.
- Serves one request at a time over a req/ack handshake: word, halfword and byte loads (sign- or zero-extended) and stores.
- Byte and halfword stores use read-modify-write on an internal word array.
- Misaligned and out-of-range accesses are rejected with an error response; memory is never written for them.

---
 rtl/mem_responder_pkg.sv | 35 +++
 rtl/mem_responder_byte_lane_unit.sv | 44 ++++
 rtl/mem_responder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
//   Shared types for the data-memory responder: access-size encoding,
//   FSM state encoding and the alignment check used when a request is
//   accepted.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DATA,
        ST_WRITE,
        ST_RESP,
        ST_ERR
    } state_t;

    // Returns 1 when the access cannot be served at this byte offset.
    // The unused size code 2'b11 is folded in here so the caller has a
    // single "bad shape" test.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_WORD: return (addr_lo != 2'b00);
            SZ_HALF: return addr_lo[0];
            SZ_BYTE: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_byte_lane_unit.sv
// byte_lane_unit
//   Combinational lane logic for sub-word accesses (little-endian lanes).
//   Ports:
//     word_i        32-bit word read from the array
//     addr_i        byte offset within the word
//     size_i        access size (word/half/byte)
//     sign_ext_i    1 = sign-extend sub-word loads, 0 = zero-extend
//     wdata_i       low 16 bits of store data
//     load_data_o   extracted and extended load result
//     merged_word_o word_i with the store data written into the addressed lane
module byte_lane_unit
    import mem_responder_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [15:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_word_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word_i[{addr_i, 3'b000} +: 8];
        half_lane = word_i[{addr_i[1], 4'b0000} +: 16];

        case (size_i)
            SZ_HALF: load_data_o = {{16{sign_ext_i & half_lane[15]}}, half_lane};
            SZ_BYTE: load_data_o = {{24{sign_ext_i & byte_lane[7]}}, byte_lane};
            default: load_data_o = word_i;
        endcase

        merged_word_o = word_i;
        case (size_i)
            SZ_HALF: merged_word_o[{addr_i[1], 4'b0000} +: 16] = wdata_i;
            SZ_BYTE: merged_word_o[{addr_i, 3'b000} +: 8]      = wdata_i[7:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Data-memory responder for the multicycle CPU. One request at a time over
//   a req/ack handshake; word/half/byte loads and stores, sub-word stores by
//   read-modify-write. Misaligned or out-of-range requests get an error ack
//   and never touch the array.
//   Ports:
//     clock     rising-edge clock
//     reset     asynchronous active-low reset
//     req       request valid, held until ack
//     we        1 = store, 0 = load
//     size      00 word, 01 half, 10 byte, 11 illegal
//     sign_ext  sub-word load extension select
//     addr      byte address
//     wdata     store data (low 8/16 bits for sub-word stores)
//     ack       one-cycle completion pulse
//     rdata     load result, held until the next load completes
//     addr_err  with ack: request rejected
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        addr_err
);

    localparam int AW = $clog2(DEPTH);

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q;
    logic [1:0]    addr_lo_q;
    logic          we_q;
    logic [1:0]    size_q;
    logic          sext_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [31:0]   rd_word_q;
    logic [31:0]   mem_q [DEPTH];

    logic          req_err;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   load_data;
    logic [31:0]   merged_word;

    // Routing decision is made from the inputs on the sampling edge; these
    // are the same values that get latched on that edge.
    assign req_err = is_misaligned(size, addr[1:0]) || (addr[31:AW+2] != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (req_err)                  state_d = ST_ERR;
                    else if (we && size == SZ_WORD) state_d = ST_WRITE;
                    else                          state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_DATA;
            ST_DATA:  state_d = ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            addr_lo_q <= '0;
            we_q      <= 1'b0;
            size_q    <= '0;
            sext_q    <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req) begin
                idx_q     <= addr[AW+1:2];
                addr_lo_q <= addr[1:0];
                we_q      <= we;
                size_q    <= size;
                sext_q    <= sign_ext;
                wdata_q   <= wdata;
            end
            if (state_q == ST_DATA && !we_q) rdata_q <= load_data;
        end
    end

    byte_lane_unit u_lane (
        .word_i        (rd_word_q),
        .addr_i        (addr_lo_q),
        .size_i        (size_q),
        .sign_ext_i    (sext_q),
        .wdata_i       (wdata_q[15:0]),
        .load_data_o   (load_data),
        .merged_word_o (merged_word)
    );

    // Write enable comes straight from the state register, so an
    // asynchronous reset drops it before the next edge and aborts the write.
    assign mem_we    = (state_q == ST_WRITE) || (state_q == ST_DATA && we_q);
    assign mem_wdata = (state_q == ST_WRITE) ? wdata_q : merged_word;

    // Array is deliberately not reset.
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[idx_q] <= mem_wdata;
        if (state_q == ST_READ) rd_word_q <= mem_q[idx_q];
    end

    assign ack      = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign addr_err = (state_q == ST_ERR);
    assign rdata    = rdata_q;

endmodule
